// File: rtl/mult_seq_pkg.sv
// Shared constants, state encoding and operand helpers for the sequential multiplier.
package mult_seq_pkg;

  localparam int unsigned WIDTH     = 32;
  localparam int unsigned MUL_STEPS = 32;
  localparam int unsigned CNT_W     = 5;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StCalc = 2'd1,
    StFix  = 2'd2
  } mul_state_e;

  // 0x80000000 maps to itself, which is the correct unsigned magnitude of -2^31.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x,
                                                 input logic             is_signed);
    return (is_signed && x[WIDTH-1]) ? (~x + WIDTH'(1)) : x;
  endfunction

endpackage

// File: rtl/mult_seq.sv
// Radix-2 shift-add 32x32 multiplier for MULT/MULTU with a divider-style start/busy handshake.
// Multiplies magnitudes over 32 steps, then sign-corrects the 64-bit product in one FIX cycle.
module mult_seq
  import mult_seq_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_is_signed,
  input  logic             i_start,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo,
  output logic             o_busy,
  output logic             o_done
);

  localparam logic [CNT_W-1:0] LastStep = CNT_W'(MUL_STEPS - 1);

  mul_state_e         r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_acc;
  logic [WIDTH-1:0]   r_mplr;
  logic [WIDTH-1:0]   r_mcand;
  logic               r_neg;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_busy;
  logic               r_done;

  logic [WIDTH-1:0]   w_addend;
  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_prod_fix;

  assign w_addend   = r_mplr[0] ? r_mcand : '0;
  assign w_sum      = {1'b0, r_acc} + {1'b0, w_addend};
  assign w_prod     = {r_acc, r_mplr};
  assign w_prod_fix = r_neg ? (~w_prod + (2*WIDTH)'(1)) : w_prod;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_acc   <= '0;
      r_mplr  <= '0;
      r_mcand <= '0;
      r_neg   <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          r_done <= 1'b0;
          if (i_start) begin
            r_mcand <= magnitude(i_a, i_is_signed);
            r_mplr  <= magnitude(i_b, i_is_signed);
            r_neg   <= i_is_signed & (i_a[WIDTH-1] ^ i_b[WIDTH-1]);
            r_acc   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= StCalc;
          end
        end
        StCalc: begin
          // Carry out of the adder shifts into acc[31] as the 65-bit value moves right.
          {r_acc, r_mplr} <= {w_sum, r_mplr[WIDTH-1:1]};
          r_cnt           <= r_cnt + CNT_W'(1);
          if (r_cnt == LastStep) begin
            r_state <= StFix;
          end
        end
        StFix: begin
          r_hi    <= w_prod_fix[2*WIDTH-1:WIDTH];
          r_lo    <= w_prod_fix[WIDTH-1:0];
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_cnt   <= '0;
          r_state <= StIdle;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign o_hi   = r_hi;
  assign o_lo   = r_lo;
  assign o_busy = r_busy;
  assign o_done = r_done;

endmodule
